// File: rtl/uart_word_tx.sv
// Serialises a 32-bit word as four back-to-back 8N1 UART frames.
// Accepts on tx_valid_i & tx_ready_o and holds the word until the last stop bit has been sent.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        drop_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt, bit_inc;
  logic [1:0]        byte_cnt, byte_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [7:0]        cur_byte;
  logic              tx_nxt, busy_nxt, done_nxt, drop_nxt;
  logic              baud_end;

  assign tx_ready_o = (state == IDLE);
  assign baud_end   = (baud_cnt == BAUD_MAX);
  assign bit_inc    = bit_cnt + 3'd1;
  // The byte on the wire always sits at the leading end of the shift register.
  assign cur_byte   = MSB_FIRST ? shreg[31:24] : shreg[7:0];

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    shreg_nxt = shreg;
    tx_nxt    = tx_o;
    busy_nxt  = busy_o;
    done_nxt  = 1'b0;
    drop_nxt  = drop_o | (tx_valid_i & ~tx_ready_o);

    if (state != IDLE) begin
      baud_nxt = baud_end ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        if (tx_valid_i) begin
          state_nxt = START;
          shreg_nxt = tx_data_i;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          baud_nxt  = '0;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_inc;
            tx_nxt  = cur_byte[bit_inc];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (byte_cnt == 2'd3) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            // Next start bit follows the stop bit directly, no idle gap.
            state_nxt = START;
            byte_nxt  = byte_cnt + 2'd1;
            tx_nxt    = 1'b0;
            shreg_nxt = MSB_FIRST ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      drop_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      tx_o     <= tx_nxt;
      busy_o   <= busy_nxt;
      done_o   <= done_nxt;
      drop_o   <= drop_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at CLKS_PER_BIT=4, MSB_FIRST=1.
module tb_uart_word_tx;

  localparam int N    = 4;
  localparam int FW   = 40 * N;
  localparam int MAXJ = 400;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic        tx_ready_o, tx_o, busy_o, done_o, drop_o;

  int checks = 0;
  int failures = 0;

  logic line_w [0:MAXJ-1];
  logic done_w [0:MAXJ-1];
  logic busy_w [0:MAXJ-1];
  logic ready_w[0:MAXJ-1];
  logic drop_w [0:MAXJ-1];

  uart_word_tx #(.CLKS_PER_BIT(N), .MSB_FIRST(1'b1)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_data_i  (tx_data_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .drop_o     (drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected line level j cycles after the accept edge; sb holds bytes in send order.
  function automatic logic exp_line(input logic [31:0] sb, input int j);
    int k, b, p;
    k = j / N;
    if (k >= 40) return 1'b1;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return sb[24 - 8*b + p - 1];
  endfunction

  function automatic int wave_errs(input logic [31:0] sb, input int off);
    int e = 0;
    for (int j = 0; j <= FW; j++)
      if (line_w[off+j] !== exp_line(sb, j)) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode_byte(input int off, input int b);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = line_w[off + (b*10 + 1 + i)*N + N/2];
    return d;
  endfunction

  function automatic int done_count(input int from, input int to);
    int c = 0;
    for (int j = from; j <= to; j++) if (done_w[j] === 1'b1) c++;
    return c;
  endfunction

  task automatic start_word(input logic [31:0] data, input logic hold, input logic [31:0] next_data);
    @(negedge clk_i);
    tx_valid_i = 1'b1;
    tx_data_i  = data;
    @(posedge clk_i);
    #1;
    if (!hold) tx_valid_i = 1'b0;
    tx_data_i = next_data;
  endtask

  task automatic capture(input int len, input int pulse_at, input logic [31:0] pulse_data, input int release_at);
    for (int j = 0; j < len; j++) begin
      @(negedge clk_i);
      line_w[j] = tx_o; done_w[j] = done_o; busy_w[j] = busy_o;
      ready_w[j] = tx_ready_o; drop_w[j] = drop_o;
      if (pulse_at >= 0 && j == pulse_at) begin
        tx_valid_i = 1'b1;
        tx_data_i  = pulse_data;
      end else if ((pulse_at >= 0 && j == pulse_at + 1) || j == release_at) begin
        tx_valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({tx_o, tx_ready_o, busy_o, done_o, drop_o} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_during: got %b want 11000", {tx_o, tx_ready_o, busy_o, done_o, drop_o});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      checks++;
      if ({tx_o, tx_ready_o, busy_o, done_o, drop_o} !== 5'b11000) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got %b want 11000", c, {tx_o, tx_ready_o, busy_o, done_o, drop_o});
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_b [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    int e;
    start_word(32'h12345678, 1'b0, 32'hEDCBA987);
    capture(FW + 1, -10, 32'h0, -1);
    checks++;
    if (ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_accept: ready=%b busy=%b want ready=0 busy=1", ready_w[0], busy_w[0]);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (decode_byte(0, b) !== exp_b[b]) begin
        failures++;
        $display("FAIL basic_byte%0d: got %h want %h", b, decode_byte(0, b), exp_b[b]);
      end
    end
    e = wave_errs(32'h12345678, 0);
    checks++;
    if (e !== 0) begin
      failures++;
      $display("FAIL basic_wave: %0d bad cycles want 0", e);
    end
    checks++;
    if (done_w[FW] !== 1'b1 || done_count(0, FW) !== 1) begin
      failures++;
      $display("FAIL basic_done: done@160=%b pulses=%0d want 1/1", done_w[FW], done_count(0, FW));
    end
    checks++;
    if (busy_w[FW-1] !== 1'b1 || busy_w[FW] !== 1'b0 || ready_w[FW] !== 1'b1) begin
      failures++;
      $display("FAIL basic_end: busy159=%b busy160=%b ready160=%b want 1 0 1", busy_w[FW-1], busy_w[FW], ready_w[FW]);
    end
  endtask

  task automatic test_ffff0000;
    logic [7:0] exp_b [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    int z0, z1, e;
    start_word(32'hFFFF0000, 1'b0, 32'h0);
    capture(FW + 1, -10, 32'h0, -1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (decode_byte(0, b) !== exp_b[b]) begin
        failures++;
        $display("FAIL ffff_byte%0d: got %h want %h", b, decode_byte(0, b), exp_b[b]);
      end
    end
    z0 = 0; while (z0 < 10 && line_w[z0] === 1'b0) z0++;
    z1 = 0; while (z1 < 10 && line_w[40 + z1] === 1'b0) z1++;
    checks++;
    if (z0 !== 4 || z1 !== 4) begin
      failures++;
      $display("FAIL ffff_start_len: byte0 %0d byte1 %0d cycles low want 4", z0, z1);
    end
    e = wave_errs(32'hFFFF0000, 0);
    checks++;
    if (e !== 0) begin
      failures++;
      $display("FAIL ffff_wave: %0d bad cycles want 0", e);
    end
  endtask

  task automatic test_drop;
    int e;
    checks++;
    if (drop_o !== 1'b0) begin
      failures++;
      $display("FAIL drop_pre: got %b want 0", drop_o);
    end
    start_word(32'hC35A0180, 1'b0, 32'h0);
    capture(FW + 1, 20, 32'h11223344, -1);
    e = wave_errs(32'hC35A0180, 0);
    checks++;
    if (e !== 0 || done_count(0, FW) !== 1) begin
      failures++;
      $display("FAIL drop_frame: %0d bad cycles, %0d done pulses want 0/1", e, done_count(0, FW));
    end
    checks++;
    if (drop_w[20] !== 1'b0 || drop_w[21] !== 1'b1 || drop_w[FW] !== 1'b1) begin
      failures++;
      $display("FAIL drop_flag: d20=%b d21=%b d160=%b want 0 1 1", drop_w[20], drop_w[21], drop_w[FW]);
    end
    repeat (50) @(negedge clk_i);
    checks++;
    if ({drop_o, tx_o, tx_ready_o, busy_o} !== 4'b1110) begin
      failures++;
      $display("FAIL drop_sticky: got %b want 1110", {drop_o, tx_o, tx_ready_o, busy_o});
    end
  endtask

  task automatic test_back_to_back;
    int e1, e2;
    start_word(32'hA5A5A5A5, 1'b1, 32'h0000002A);
    capture(2*FW + 2, -10, 32'h0, FW + 1);
    e1 = wave_errs(32'hA5A5A5A5, 0);
    e2 = wave_errs(32'h0000002A, FW + 1);
    checks++;
    if (e1 !== 0 || e2 !== 0) begin
      failures++;
      $display("FAIL b2b_wave: word1 %0d word2 %0d bad cycles want 0", e1, e2);
    end
    checks++;
    if (done_w[FW] !== 1'b1 || ready_w[FW] !== 1'b1 || busy_w[FW+1] !== 1'b1 || line_w[FW+1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_handover: done=%b ready=%b busy=%b tx=%b want 1 1 1 0",
               done_w[FW], ready_w[FW], busy_w[FW+1], line_w[FW+1]);
    end
    checks++;
    if (done_w[2*FW+1] !== 1'b1 || done_count(0, 2*FW+1) !== 2) begin
      failures++;
      $display("FAIL b2b_done: last=%b pulses=%0d want 1/2", done_w[2*FW+1], done_count(0, 2*FW+1));
    end
    checks++;
    if (decode_byte(FW + 1, 3) !== 8'h2A || decode_byte(0, 0) !== 8'hA5) begin
      failures++;
      $display("FAIL b2b_bytes: got %h %h want a5 2a", decode_byte(0, 0), decode_byte(FW + 1, 3));
    end
  endtask

  task automatic test_reset_mid;
    int bad, e;
    start_word(32'h12345678, 1'b0, 32'h0);
    capture(86, -10, 32'h0, -1);
    checks++;
    if (line_w[85] !== 1'b0 || busy_w[85] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: tx=%b busy=%b want 0 1", line_w[85], busy_w[85]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_o, tx_ready_o, busy_o, done_o, drop_o} !== 5'b11000) begin
      failures++;
      $display("FAIL mid_async: got %b want 11000", {tx_o, tx_ready_o, busy_o, done_o, drop_o});
    end
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_ready_o !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mid_no_resume: %0d non-idle cycles want 0", bad);
    end
    start_word(32'h0F1E2D3C, 1'b0, 32'h0);
    capture(FW + 1, -10, 32'h0, -1);
    e = wave_errs(32'h0F1E2D3C, 0);
    checks++;
    if (e !== 0 || decode_byte(0, 0) !== 8'h0F || decode_byte(0, 3) !== 8'h3C) begin
      failures++;
      $display("FAIL mid_next_word: %0d bad cycles, bytes %h %h want 0/0f/3c", e, decode_byte(0, 0), decode_byte(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ffff0000;
    test_drop;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
